// File: rtl/response_uart_tx.sv
// Sends each full PUF response byte as one 8N1 UART frame, then pulses
// ack_reset to clear the race bit buffer and re-arm it.
module response_uart_tx #(
  parameter int CLKS_PER_BIT     = 104,
  parameter int ACK_PULSE_CYCLES = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ready_to_read,
  input  logic [7:0] data_in,
  input  logic       tx_enable,
  output logic       tx,
  output logic       busy,
  output logic       ack_reset,
  output logic [7:0] frames_sent
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int AW = (ACK_PULSE_CYCLES > 1) ? $clog2(ACK_PULSE_CYCLES) : 1;
  localparam logic [BW-1:0] BAUD_LOAD = BW'(CLKS_PER_BIT - 1);
  localparam logic [AW-1:0] ACK_LOAD  = AW'(ACK_PULSE_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, ACK} state_t;

  state_t        state;
  logic [7:0]    shreg;
  logic [BW-1:0] baud;
  logic [2:0]    bit_idx;
  logic [AW-1:0] ack_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      tx          <= 1'b1;
      busy        <= 1'b0;
      ack_reset   <= 1'b0;
      frames_sent <= '0;
      shreg       <= '0;
      baud        <= '0;
      bit_idx     <= '0;
      ack_cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          tx        <= 1'b1;
          busy      <= 1'b0;
          ack_reset <= 1'b0;
          if (ready_to_read && tx_enable) begin
            shreg   <= data_in;
            baud    <= BAUD_LOAD;
            bit_idx <= '0;
            tx      <= 1'b0;
            busy    <= 1'b1;
            state   <= START;
          end
        end
        START: begin
          if (baud == '0) begin
            baud  <= BAUD_LOAD;
            tx    <= shreg[0];
            state <= DATA;
          end else begin
            baud <= baud - 1'b1;
          end
        end
        DATA: begin
          // shreg[0] is always the bit on the line; shift after each bit
          if (baud == '0) begin
            baud <= BAUD_LOAD;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              tx      <= shreg[1];
              shreg   <= {1'b0, shreg[7:1]};
            end
          end else begin
            baud <= baud - 1'b1;
          end
        end
        STOP: begin
          if (baud == '0) begin
            frames_sent <= frames_sent + 1'b1;
            ack_cnt     <= ACK_LOAD;
            ack_reset   <= 1'b1;
            state       <= ACK;
          end else begin
            baud <= baud - 1'b1;
          end
        end
        ACK: begin
          if (ack_cnt == '0) begin
            ack_reset <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            ack_cnt <= ack_cnt - 1'b1;
          end
        end
        default: begin
          tx        <= 1'b1;
          busy      <= 1'b0;
          ack_reset <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end
endmodule
